// File: rtl/morph_pkg.sv
// Shared definitions for the binary morphology filter: mode encoding,
// legal window sizes and the border fill value.
package morph_pkg;

    typedef enum logic {
        MODE_ERODE  = 1'b0,
        MODE_DILATE = 1'b1
    } mode_e;

    localparam int KSIZE_MIN = 3;
    localparam int KSIZE_MAX = 5;

    // Value that leaves the reduction unchanged: 1 for AND, 0 for OR.
    function automatic logic neutral(input mode_e m);
        return (m == MODE_ERODE);
    endfunction

endpackage

// File: rtl/morph_filter_if.sv
// Pixel stream in/out bundle for morph_filter; no backpressure, vld qualifies sop/eop.
interface morph_filter_if;
    logic din;
    logic din_sop;
    logic din_eop;
    logic din_vld;
    logic mode;
    logic dout;
    logic dout_sop;
    logic dout_eop;
    logic dout_vld;

    modport master (
        output din, din_sop, din_eop, din_vld, mode,
        input  dout, dout_sop, dout_eop, dout_vld
    );

    modport slave (
        input  din, din_sop, din_eop, din_vld, mode,
        output dout, dout_sop, dout_eop, dout_vld
    );
endinterface

// File: rtl/morph_line_buf.sv
// Cascaded 1-bit line RAMs, async read / sync write; tap k is the pixel k+1 lines back.
// Zero latency on taps, no backpressure: writes on every enabled beat, contents never cleared.
module morph_line_buf #(
    parameter int  IMG_W = 640,
    parameter int  DEPTH = 2,
    localparam int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic             din_i,
    output logic [DEPTH-1:0] taps_o
);

    logic mem [DEPTH][IMG_W];

    // Each line pushes its old value down one line, so a same-address read sees old data.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[0][addr_i] <= din_i;
            for (int k = 1; k < DEPTH; k++) begin
                mem[k][addr_i] <= mem[k-1][addr_i];
            end
        end
    end

    always_comb begin
        taps_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            taps_o[k] = mem[k][addr_i];
        end
    end

endmodule

// File: rtl/morph_filter.sv
// KxK binary erode/dilate on a raster pixel stream, window anchored at its bottom-right pixel.
// Latency 2 clk, vld/sop/eop gaps preserved; no backpressure, beats before the first sop after reset are dropped.
module morph_filter
    import morph_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int KSIZE = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    morph_filter_if.slave io
);

    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DEPTH = KSIZE - 1;
    localparam int NWIN  = KSIZE * KSIZE;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    if (KSIZE != KSIZE_MIN && KSIZE != KSIZE_MAX) begin : g_ksize_check
        $error("morph_filter: KSIZE must be 3 or 5");
    end

    logic             act_q, act_d;
    mode_e            mode_q, mode_d;
    logic [CW-1:0]    col_q, col_d, cur_col;
    logic [RW-1:0]    row_q, row_d, cur_row;
    logic             beat;
    logic [DEPTH-1:0] taps;
    logic [KSIZE-1:0] newcol;
    logic [NWIN-1:0]  win_q, win_d, eff;
    logic [KSIZE-1:0] rmask_q, rmask_d, cmask_q, cmask_d;
    logic             s1_vld_q, s1_sop_q, s1_eop_q;
    logic             dout_q, dout_d, dout_vld_q, dout_sop_q, dout_eop_q;

    // A beat counts only once a frame has been opened by sop since reset.
    assign beat    = io.din_vld & (io.din_sop | act_q);
    assign cur_col = io.din_sop ? '0 : col_q;
    assign cur_row = io.din_sop ? '0 : row_q;
    assign newcol  = {taps, io.din};

    morph_line_buf #(
        .IMG_W (IMG_W),
        .DEPTH (DEPTH)
    ) u_line_buf (
        .clk     (clk),
        .wr_en_i (beat),
        .addr_i  (cur_col),
        .din_i   (io.din),
        .taps_o  (taps)
    );

    // Stage 1: position counters, window shift and border masks.
    always_comb begin
        act_d   = act_q;
        mode_d  = mode_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        rmask_d = rmask_q;
        cmask_d = cmask_q;
        if (beat) begin
            act_d = 1'b1;
            if (io.din_sop) begin
                mode_d = mode_e'(io.mode);
            end
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? cur_row : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            // Bit i*K+j holds the pixel i rows up and j columns left of the newest one.
            for (int i = 0; i < KSIZE; i++) begin
                win_d[i*KSIZE +: KSIZE] = {win_q[i*KSIZE +: KSIZE-1], newcol[i]};
                rmask_d[i] = (cur_row >= RW'(i));
                cmask_d[i] = (cur_col >= CW'(i));
            end
        end
    end

    // Stage 2: out-of-frame taps become neutral so stale rows/columns never reach the reduction.
    always_comb begin
        eff    = '0;
        dout_d = dout_q;
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
                eff[i*KSIZE+j] = (rmask_q[i] & cmask_q[j]) ? win_q[i*KSIZE+j] : neutral(mode_q);
            end
        end
        if (s1_vld_q) begin
            dout_d = (mode_q == MODE_DILATE) ? (|eff) : (&eff);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q      <= 1'b0;
            mode_q     <= MODE_ERODE;
            col_q      <= '0;
            row_q      <= '0;
            win_q      <= '0;
            rmask_q    <= '0;
            cmask_q    <= '0;
            s1_vld_q   <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
        end else begin
            act_q      <= act_d;
            mode_q     <= mode_d;
            col_q      <= col_d;
            row_q      <= row_d;
            win_q      <= win_d;
            rmask_q    <= rmask_d;
            cmask_q    <= cmask_d;
            s1_vld_q   <= beat;
            s1_sop_q   <= beat & io.din_sop;
            s1_eop_q   <= beat & io.din_eop;
            dout_q     <= dout_d;
            dout_vld_q <= s1_vld_q;
            dout_sop_q <= s1_sop_q;
            dout_eop_q <= s1_eop_q;
        end
    end

    assign io.dout     = dout_q;
    assign io.dout_vld = dout_vld_q;
    assign io.dout_sop = dout_sop_q;
    assign io.dout_eop = dout_eop_q;

endmodule

// File: tb/tb_morph_filter.sv
// Bench for morph_filter on an 8x6 frame with K=3 and K=5 instances fed the same stream.
module tb_morph_filter;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int NP = W * H;
    localparam int NV = 9;

    typedef struct {
        logic          m;
        logic [NP-1:0] img;
        logic [NP-1:0] e3;
        logic [NP-1:0] e5;
    } vec_t;

    typedef struct {
        logic d;
        logic s;
        logic e;
        int   stamp;
        int   r;
        int   c;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    morph_filter_if if3 ();
    morph_filter_if if5 ();

    assign if5.din     = if3.din;
    assign if5.din_sop = if3.din_sop;
    assign if5.din_eop = if3.din_eop;
    assign if5.din_vld = if3.din_vld;
    assign if5.mode    = if3.mode;

    morph_filter #(.IMG_W(W), .IMG_H(H), .KSIZE(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (if3)
    );

    morph_filter #(.IMG_W(W), .IMG_H(H), .KSIZE(5)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (if5)
    );

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    vec_t  vt [NV];
    beat_t q3[$], q5[$], cap3[$], cap5[$];
    logic  img_m [H][W];
    logic  m_act  = 1'b0;
    logic  m_mode = 1'b0;
    int    m_row  = 0;
    int    m_col  = 0;
    logic  last3  = 1'b0;
    logic  last5  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: reduce the KxK window ending at (r,c), out-of-frame taps take the neutral value.
    function automatic logic ref_px(input int k, input logic m, input int r, input int c);
        logic acc;
        logic v;
        acc = ~m;
        for (int i = 0; i < k; i++) begin
            for (int j = 0; j < k; j++) begin
                if (r - i < 0 || c - j < 0) v = ~m;
                else                        v = img_m[r-i][c-j];
                acc = m ? (acc | v) : (acc & v);
            end
        end
        return acc;
    endfunction

    task automatic out_chk(input int k, input logic d, input logic s, input logic e, input logic v);
        beat_t x;
        if (v) begin
            if (k == 3) cap3.push_back('{d, s, e, cyc, 0, 0});
            else        cap5.push_back('{d, s, e, cyc, 0, 0});
            if ((k == 3 && q3.size() == 0) || (k == 5 && q5.size() == 0)) begin
                n_vec++;
                n_err++;
                $display("FAIL k%0d unexpected output beat at cycle %0d: got vld=1, expected none", k, cyc);
            end else begin
                if (k == 3) x = q3.pop_front();
                else        x = q5.pop_front();
                chk($sformatf("k%0d dout (%0d,%0d)", k, x.r, x.c), 32'(d), 32'(x.d));
                chk($sformatf("k%0d sop (%0d,%0d)", k, x.r, x.c), 32'(s), 32'(x.s));
                chk($sformatf("k%0d eop (%0d,%0d)", k, x.r, x.c), 32'(e), 32'(x.e));
                chk($sformatf("k%0d latency (%0d,%0d)", k, x.r, x.c), cyc - x.stamp, 32'd2);
            end
            if (k == 3) last3 = d;
            else        last5 = d;
        end else begin
            chk($sformatf("k%0d dout hold cycle %0d", k, cyc), 32'(d), 32'(k == 3 ? last3 : last5));
        end
    endtask

    // Monitor: inputs and outputs are both stable at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("k3 outputs in reset", 32'({if3.dout, if3.dout_vld, if3.dout_sop, if3.dout_eop}), 32'd0);
            chk("k5 outputs in reset", 32'({if5.dout, if5.dout_vld, if5.dout_sop, if5.dout_eop}), 32'd0);
            q3.delete();
            q5.delete();
            m_act  = 1'b0;
            m_mode = 1'b0;
            m_row  = 0;
            m_col  = 0;
            last3  = 1'b0;
            last5  = 1'b0;
        end else begin
            out_chk(3, if3.dout, if3.dout_sop, if3.dout_eop, if3.dout_vld);
            out_chk(5, if5.dout, if5.dout_sop, if5.dout_eop, if5.dout_vld);
            if (if3.din_vld && (if3.din_sop || m_act)) begin
                if (if3.din_sop) begin
                    m_act  = 1'b1;
                    m_mode = if3.mode;
                    m_row  = 0;
                    m_col  = 0;
                end
                img_m[m_row][m_col] = if3.din;
                q3.push_back('{ref_px(3, m_mode, m_row, m_col), if3.din_sop, if3.din_eop, cyc, m_row, m_col});
                q5.push_back('{ref_px(5, m_mode, m_row, m_col), if3.din_sop, if3.din_eop, cyc, m_row, m_col});
                if (m_col == W - 1) begin
                    m_col = 0;
                    if (m_row < H - 1) m_row++;
                end else begin
                    m_col++;
                end
            end
        end
    end

    task automatic drive(input logic d, input logic s, input logic e, input logic v, input logic m);
        @(posedge clk);
        #1;
        if3.din     = d;
        if3.din_sop = s;
        if3.din_eop = e;
        if3.din_vld = v;
        if3.mode    = m;
    endtask

    task automatic idle();
        drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        if3.din_vld = 1'b0;
        if3.din_sop = 1'b0;
        if3.din_eop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [NP-1:0] px, input logic m, input bit gaps,
                              input bit tog, input int rst_at);
        for (int b = 0; b < NP; b++) begin
            if (b == rst_at) pulse_reset();
            if (gaps) begin
                for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) idle();
            end
            drive(px[b], b == 0, b == NP - 1, 1'b1, (tog && b >= 20) ? ~m : m);
        end
    endtask

    function automatic logic [NP-1:0] rand_img(input logic base);
        logic [NP-1:0] p;
        for (int b = 0; b < NP; b++) p[b] = ($urandom_range(0, 3) == 0) ? ~base : base;
        return p;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded 200000 time units, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Bit r*8+c is pixel (r,c); expectations worked out by hand for K=3 and K=5.
        vt[0] = '{1'b0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF};
        vt[1] = '{1'b0, 48'hFFFF_FFF7_FFFF, 48'hFFC7_C7C7_FFFF, 48'h0707_0707_FFFF};
        vt[2] = '{1'b1, 48'h0000_0000_0001, 48'h0000_0007_0707, 48'h001F_1F1F_1F1F};
        vt[3] = '{1'b1, 48'h8000_0000_0000, 48'h8000_0000_0000, 48'h8000_0000_0000};
        vt[4] = '{1'b0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF};
        vt[5] = '{1'b0, 48'h0000_0000_0000, 48'h0000_0000_0000, 48'h0000_0000_0000};
        vt[6] = '{1'b0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF};
        vt[7] = '{1'b1, 48'h0000_4000_0000, 48'hC0C0_C000_0000, 48'hC0C0_C000_0000};
        vt[8] = '{1'b1, 48'h0000_0000_0000, 48'h0000_0000_0000, 48'h0000_0000_0000};

        if3.din     = 1'b0;
        if3.din_sop = 1'b0;
        if3.din_eop = 1'b0;
        if3.din_vld = 1'b0;
        if3.mode    = 1'b0;
        rst_n       = 1'b1;
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            cap3.delete();
            cap5.delete();
            send_frame(vt[v].img, vt[v].m, 1'b0, 1'b0, -1);
            repeat (4) idle();
            chk($sformatf("v%0d k3 beat count", v), cap3.size(), NP);
            chk($sformatf("v%0d k5 beat count", v), cap5.size(), NP);
            for (int b = 0; b < NP && b < cap3.size(); b++) begin
                chk($sformatf("v%0d k3 dout beat %0d", v, b), 32'(cap3[b].d), 32'(vt[v].e3[b]));
                chk($sformatf("v%0d k3 sop beat %0d", v, b), 32'(cap3[b].s), 32'(b == 0));
                chk($sformatf("v%0d k3 eop beat %0d", v, b), 32'(cap3[b].e), 32'(b == NP - 1));
            end
            for (int b = 0; b < NP && b < cap5.size(); b++) begin
                chk($sformatf("v%0d k5 dout beat %0d", v, b), 32'(cap5[b].d), 32'(vt[v].e5[b]));
            end
        end

        // Gapped dilate frame with the mode pin flipped after beat 20.
        send_frame(rand_img(1'b0), 1'b1, 1'b1, 1'b1, -1);
        repeat (3) idle();
        // Erode frame cut by reset at beat 30; the rest of it must produce nothing.
        send_frame(rand_img(1'b1), 1'b0, 1'b1, 1'b0, 30);
        repeat (3) idle();
        // Truncated dilate frame restarted by a fresh sop.
        for (int b = 0; b < 13; b++) drive(1'($urandom_range(0, 1)), b == 0, 1'b0, 1'b1, 1'b1);
        send_frame(rand_img(1'b1), 1'b0, 1'b1, 1'b1, -1);
        send_frame(rand_img(1'b0), 1'b1, 1'b0, 1'b0, -1);
        repeat (6) idle();
        chk("k3 pending expected beats at end", q3.size(), 32'd0);
        chk("k5 pending expected beats at end", q5.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
